// File: rtl/seg_frame_ctrl.sv
// Double-buffered 16x16-bit segment frame with round-robin write arbitration
// and tick-aligned commit, so the displayed frame is never torn.
module seg_frame_ctrl #(
  parameter int unsigned FRAME_DIV = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_a,
  input  logic [3:0]   addr_a,
  input  logic [15:0]  data_a,
  output logic         ack_a,
  input  logic         req_b,
  input  logic [3:0]   addr_b,
  input  logic [15:0]  data_b,
  output logic         ack_b,
  input  logic         commit_req,
  output logic         frame_tick,
  output logic         busy,
  output logic [255:0] out_seg
);

  localparam int unsigned CNT_W  = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned NWORDS = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COPY    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_b_q;
  logic [WORD_W-1:0]  shadow_q [NWORDS];

  logic               gnt_a, gnt_b;
  logic               wr_en;
  logic [3:0]         wr_addr;
  logic [WORD_W-1:0]  wr_data;

  assign frame_tick = (cnt_q == CNT_W'(FRAME_DIV - 1));
  assign busy       = (state_q != IDLE);
  assign ack_a      = gnt_a;
  assign ack_b      = gnt_b;

  // Free-running frame counter; keeps counting through COPY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (frame_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit_req) state_d = frame_tick ? COPY : PENDING;
      PENDING: if (frame_tick) state_d = COPY;
      COPY:    state_d = commit_req ? PENDING : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Round-robin: on a tie the requester not granted last wins.
  always_comb begin
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (reset && (state_q != COPY)) begin
      gnt_a = req_a && (!req_b || last_b_q);
      gnt_b = req_b && !gnt_a;
    end
    if (gnt_a) begin
      wr_en   = 1'b1;
      wr_addr = addr_a;
      wr_data = data_a;
    end else if (gnt_b) begin
      wr_en   = 1'b1;
      wr_addr = addr_b;
      wr_data = data_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_b_q <= 1'b1;
    end else if (gnt_a) begin
      last_b_q <= 1'b0;
    end else if (gnt_b) begin
      last_b_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < int'(NWORDS); k++) shadow_q[k] <= '0;
    end else if (wr_en) begin
      shadow_q[wr_addr] <= wr_data;
    end
  end

  // Publish the whole shadow frame at the edge that ends COPY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_seg <= '0;
    end else if (state_q == COPY) begin
      for (int k = 0; k < int'(NWORDS); k++) out_seg[WORD_W*k +: WORD_W] <= shadow_q[k];
    end
  end

endmodule

// File: tb/tb_seg_frame_ctrl.sv
// Bench for seg_frame_ctrl: directed scenarios plus random two-requester
// traffic, all checked against a frame-level reference model.
module tb_seg_frame_ctrl;

  localparam int unsigned FD = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_a, req_b, commit_req;
  logic [3:0]   addr_a, addr_b;
  logic [15:0]  data_a, data_b;
  logic         ack_a, ack_b, frame_tick, busy;
  logic [255:0] out_seg;

  always #5 clk = ~clk;

  seg_frame_ctrl #(.FRAME_DIV(FD)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .ack_b(ack_b),
    .commit_req(commit_req), .frame_tick(frame_tick), .busy(busy),
    .out_seg(out_seg)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: frames as word arrays, commit as pending/copy flags.
  logic [15:0] m_shadow [16];
  logic [15:0] m_out    [16];
  int          m_cnt;
  bit          m_pend, m_copy, m_last_b;
  bit          g_a, g_b;
  logic        s_ack_a, s_ack_b, s_tick;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [255:0] model_frame();
    logic [255:0] r;
    for (int k = 0; k < 16; k++) r[16*k +: 16] = m_out[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      m_shadow[k] = '0;
      m_out[k]    = '0;
    end
    m_cnt = 0; m_pend = 0; m_copy = 0; m_last_b = 1; g_a = 0; g_b = 0;
  endtask

  // One clock: check outputs mid-cycle, advance the model, step past the edge.
  task automatic cycle();
    bit tick;
    @(negedge clk);
    tick = (m_cnt == FD - 1);
    g_a  = !m_copy && req_a && (!req_b || m_last_b);
    g_b  = !m_copy && req_b && !g_a;
    s_ack_a = ack_a; s_ack_b = ack_b; s_tick = frame_tick;
    check("ack_a", ack_a, g_a);
    check("ack_b", ack_b, g_b);
    check("frame_tick", frame_tick, tick);
    check("busy", busy, m_pend || m_copy);
    check("out_seg", out_seg, model_frame());
    if (m_copy) begin
      m_out  = m_shadow;
      m_copy = 0;
      m_pend = commit_req;
    end else if ((m_pend || commit_req) && tick) begin
      m_copy = 1;
      m_pend = 0;
    end else begin
      m_pend = m_pend || commit_req;
    end
    if (g_a) begin m_shadow[addr_a] = data_a; m_last_b = 0; end
    if (g_b) begin m_shadow[addr_b] = data_b; m_last_b = 1; end
    m_cnt = (m_cnt + 1) % FD;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; req_a = 1'b1; req_b = 1'b0; commit_req = 1'b0;
    addr_a = 4'd0; data_a = 16'h0; addr_b = 4'd0; data_b = 16'h0;
    model_reset();
    #1;
    check("rst_out_seg", out_seg, '0);
    check("rst_busy", busy, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("rst_ack_a", ack_a, 1'b0);
      check("rst_ack_b", ack_b, 1'b0);
      check("rst_tick", frame_tick, 1'b0);
      check("rst_out_hold", out_seg, '0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1; req_a = 1'b0;
  endtask

  task automatic commit_and_wait();
    commit_req = 1'b1;
    cycle();
    commit_req = 1'b0;
    repeat (FD + 3) cycle();
  endtask

  int first_tick, second_tick;

  initial begin
    reset = 1'b1;
    #2;
    do_reset();

    // Tick phase after release.
    first_tick = -1; second_tick = -1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (s_tick && first_tick < 0) first_tick = i;
      else if (s_tick && second_tick < 0) second_tick = i;
    end
    check("first_tick", 32'(first_tick), 32'(FD - 1));
    check("tick_period", 32'(second_tick - first_tick), 32'(FD));

    // Single write and commit.
    do_reset();
    req_a = 1'b1; addr_a = 4'd3; data_a = 16'hBEEF;
    cycle();
    req_a = 1'b0;
    commit_and_wait();
    check("single_word", out_seg[63:48], 16'hBEEF);
    check("single_rest", out_seg & ~(256'hFFFF << 48), '0);

    // Round-robin fairness with both held high.
    do_reset();
    req_a = 1'b1; addr_a = 4'd0; data_a = 16'h1000;
    req_b = 1'b1; addr_b = 4'd8; data_b = 16'h2000;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("rr_order", {s_ack_a, s_ack_b}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (s_ack_a) begin addr_a = 4'd1; data_a = 16'h1001; end
      if (s_ack_b) begin addr_b = 4'd9; data_b = 16'h2001; end
    end
    req_a = 1'b0; req_b = 1'b0;
    commit_and_wait();
    check("rr_w0", out_seg[15:0],    16'h1000);
    check("rr_w1", out_seg[31:16],   16'h1001);
    check("rr_w8", out_seg[143:128], 16'h2000);
    check("rr_w9", out_seg[159:144], 16'h2001);

    // Same-address race: A then B, B's data survives.
    do_reset();
    req_a = 1'b1; addr_a = 4'd5; data_a = 16'h1111;
    req_b = 1'b1; addr_b = 4'd5; data_b = 16'h2222;
    for (int i = 0; i < 4 && (req_a || req_b); i++) begin
      cycle();
      if (s_ack_a) req_a = 1'b0;
      if (s_ack_b) req_b = 1'b0;
    end
    check("race_done", {req_a, req_b}, 2'b00);
    commit_and_wait();
    check("race_word", out_seg[95:80], 16'h2222);

    // Commit in the tick cycle, write stalled by the following COPY.
    do_reset();
    for (int i = 0; i < 2 * FD && m_cnt != FD - 1; i++) cycle();
    commit_req = 1'b1;
    cycle();
    commit_req = 1'b0;
    req_b = 1'b1; addr_b = 4'd2; data_b = 16'hABCD;
    check("stall_busy", busy, 1'b1);
    cycle();
    check("stall_ack_copy", s_ack_b, 1'b0);
    cycle();
    check("stall_ack_after", s_ack_b, 1'b1);
    req_b = 1'b0;
    repeat (3) cycle();
    check("stall_absent", out_seg[47:32], 16'h0000);
    commit_and_wait();
    check("stall_present", out_seg[47:32], 16'hABCD);

    // Reset asserted during COPY aborts the copy and clears the shadow.
    req_a = 1'b1; addr_a = 4'd7; data_a = 16'h7777;
    cycle();
    req_a = 1'b0;
    commit_req = 1'b1;
    cycle();
    commit_req = 1'b0;
    for (int i = 0; i < 2 * FD && !m_copy; i++) cycle();
    check("midcopy_reached", busy, 1'b1);
    do_reset();
    commit_and_wait();
    check("midcopy_clear", out_seg, '0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      commit_req = ($urandom_range(0, 15) == 0);
      cycle();
      if (!req_a || s_ack_a) begin
        req_a  = ($urandom_range(0, 2) != 0);
        addr_a = 4'($urandom_range(0, 15));
        data_a = 16'($urandom);
      end
      if (!req_b || s_ack_b) begin
        req_b  = ($urandom_range(0, 2) != 0);
        addr_b = ($urandom_range(0, 3) == 0) ? addr_a : 4'($urandom_range(0, 15));
        data_b = 16'($urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_frame_ctrl.md
# seg_frame_ctrl

Double-buffered segment frame controller placed between the LCD simulator's input-handling logic and the 256-bit segment output bus. Two requesters write 16-bit segment words into a shadow frame through a round-robin arbiter. A commit request copies the shadow frame to the displayed frame on the next frame tick, so a display update is never torn.

## Interface

Parameters:
- FRAME_DIV, 1000: clock cycles per frame tick; legal range ≥ 2.

Ports:
- clk  in  1  system clock; all flops on the rising edge.
- reset  in  1  asynchronous, active-low reset. Asserted at 0.
- req_a  in  1  requester A write request; held until acked.
- addr_a  in  4  requester A word index 0..15.
- data_a  in  16  requester A segment word.
- ack_a  out  1  requester A write accepted this cycle (combinational).
- req_b, addr_b, data_b, ack_b: same as the A ports, for requester B.
- commit_req  in  1  single-cycle pulse: publish the shadow frame at the next tick.
- frame_tick  out  1  one-cycle pulse every FRAME_DIV cycles.
- busy  out  1  a commit is pending or in progress.
- out_seg  out  256  displayed segment frame; word k occupies bits [16k+15:16k].

## Operation

**Storage**
- shadow[255:0] is the write target.
- out_seg is a separate register that holds the displayed frame.

**Arbitration**
- At most one write is granted per cycle.
- A grant requires state ≠ COPY and reset high.
- Only one requester active: it is granted.
- Both requesters active: the one not granted last is granted.
- The last-granted pointer updates only on a grant. Its reset value is B, so A wins the first tie.
- ack_x = grant_x, combinational in the same cycle.
- The shadow word at addr_x takes data_x at the end of the granted cycle.
- A requester may present a new addr/data or drop req in the cycle after its ack.
- Equal addresses from both requesters cause no conflict, because only one is written per cycle.
- Both acks are forced to 0 while reset is low or state = COPY.

**Frame counter**
- cnt counts 0..FRAME_DIV-1 and wraps to 0.
- frame_tick = (cnt == FRAME_DIV-1).

**Commit state machine: IDLE, PENDING, COPY**
- IDLE: commit_req with no tick → PENDING. commit_req in a tick cycle → COPY.
- PENDING: tick → COPY. Further commit_req pulses are absorbed.
- COPY (one cycle): no grants. out_seg ← shadow at the end of the cycle. Then → IDLE, or → PENDING if commit_req was high during COPY.
- busy = (state ≠ IDLE).

**Reset (asynchronous)**
- shadow = 0, out_seg = 0, cnt = 0, state = IDLE, pointer = B.
- Reset asserted mid-COPY aborts the copy; out_seg reads 0.

## Timing

- Write latency: a write granted in cycle t is visible in shadow from t+1.
- out_seg changes only at the edge that ends a COPY cycle.
- Commit timing:
  - Tick in cycle T with a commit pending (or commit_req in T) → COPY in T+1 → new out_seg visible from T+2.
  - Writes granted in T are included in the copy.
  - Writes stalled in T+1 are granted from T+2 and appear only at the next commit.
- Commit latency: the worst case from commit_req to a new out_seg is FRAME_DIV+1 cycles.
- Tick counter: it keeps running through COPY, so ticks stay strictly periodic.
- Outputs during and after reset:
  - ack_a = ack_b = 0.
  - busy = 0.
  - out_seg = 0.
  - frame_tick = 0 (because FRAME_DIV ≥ 2).
- After reset release, the first tick occurs at cycle FRAME_DIV-1.

## Test plan

Use FRAME_DIV = 8 unless noted.
- **Reset values:** hold reset low with req_a = 1 → ack_a = 0, out_seg = 0, busy = 0. Release reset → the first frame_tick occurs 7 cycles later, then every 8 cycles.
- **Single write and commit:** write addr_a = 3, data_a = 16'hBEEF, then pulse commit_req → busy = 1 until COPY ends. out_seg[63:48] = 16'hBEEF from two cycles after the tick; all other bits stay 0.
- **Round-robin fairness:** req_a and req_b held high for 4 cycles, with distinct addresses → ack order A, B, A, B. Four shadow words are written, which a following commit confirms.
- **Same-address race:** both requesters target addr 5 (A = 16'h1111, B = 16'h2222), both held until acked → A first, then B. After commit, out_seg[95:80] = 16'h2222.
- **Stall and coincident commit:** commit_req in the tick cycle with req_b high → COPY in the next cycle with ack_b = 0. The write is acked one cycle later and is absent from out_seg until a second commit.
- **Reset mid-operation:** assert reset during COPY → out_seg = 0, state IDLE, busy = 0, and the shadow is cleared. A subsequent commit with no writes keeps out_seg = 0.
